// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register/ALU-op widths and the decoded control word.
package cpu_pkg;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned ALUOP_W = 4;

  typedef struct packed {
    logic write_reg;
    logic write_r0;
    logic mem_read;
    logic muldiv;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{write_reg: 1'b0, write_r0: 1'b0, mem_read: 1'b0, muldiv: 1'b0};

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use detection and decode-stall request for the ID/EX stage.
module id_ex_hazard
  import cpu_pkg::*;
(
  input  logic             ex_valid,
  input  logic             mem_read_ex,
  input  logic             write_reg_ex,
  input  logic [REG_W-1:0] rn1_ex,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rn1,
  input  logic [REG_W-1:0] rn2,
  input  logic             ex_busy,
  input  logic             flush,
  output logic             ld_use_c,
  output logic             stall_id_c
);

  // R0 is deliberately not special-cased: a plain register-number match stalls.
  always_comb begin
    ld_use_c   = ex_valid & mem_read_ex & write_reg_ex & id_valid &
                 ((rn1_ex == rn1) | (rn1_ex == rn2));
    stall_id_c = ~flush & (ex_busy | ld_use_c);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, mul/div hold and flush.
// Optional stall statistic enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   RN1,
  input  logic [REG_W-1:0]   RN2,
  input  logic [DATA_W-1:0]  op1_data,
  input  logic [DATA_W-1:0]  op2_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_write_reg,
  input  logic               id_write_r0,
  input  logic               id_mem_read,
  input  logic               id_muldiv,
  input  logic               flush,
  output logic               ex_valid,
  output logic [REG_W-1:0]   RN1_EX,
  output logic [REG_W-1:0]   RN2_EX,
  output logic [DATA_W-1:0]  op1_EX,
  output logic [DATA_W-1:0]  op2_EX,
  output logic [DATA_W-1:0]  Imm_EX,
  output logic [ALUOP_W-1:0] AluOp_EX,
  output logic               WriteReg_EX,
  output logic               WriteR0_EX,
  output logic               MemRead_EX,
  output logic               MulDiv_EX,
  output logic               ex_busy,
  output logic               stall_id,
  output logic [15:0]        stall_count
);

  localparam int unsigned CNT_W = $clog2(MULDIV_CYCLES) + 1;

  logic               ex_valid_q, ex_valid_d;
  logic [REG_W-1:0]   rn1_q, rn1_d, rn2_q, rn2_d;
  logic [DATA_W-1:0]  op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic busy_c;
  logic ld_use_c;
  logic stall_id_c;

  assign busy_c = (cnt_q != '0);

  id_ex_hazard u_hazard (
    .ex_valid     (ex_valid_q),
    .mem_read_ex  (ctrl_q.mem_read),
    .write_reg_ex (ctrl_q.write_reg),
    .rn1_ex       (rn1_q),
    .id_valid     (id_valid),
    .rn1          (RN1),
    .rn2          (RN2),
    .ex_busy      (busy_c),
    .flush        (flush),
    .ld_use_c     (ld_use_c),
    .stall_id_c   (stall_id_c)
  );

  // Priority: flush > mul/div hold > load-use bubble > advance.
  always_comb begin
    ex_valid_d = ex_valid_q;
    rn1_d      = rn1_q;
    rn2_d      = rn2_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    imm_d      = imm_q;
    alu_op_d   = alu_op_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;

    if (flush || (!busy_c && ld_use_c)) begin
      ex_valid_d = 1'b0;
      rn1_d      = '0;
      rn2_d      = '0;
      op1_d      = '0;
      op2_d      = '0;
      imm_d      = '0;
      alu_op_d   = '0;
      ctrl_d     = BUBBLE_CTRL;
      if (flush) begin
        cnt_d = '0;
      end
    end else if (busy_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      ex_valid_d = id_valid;
      rn1_d      = RN1;
      rn2_d      = RN2;
      op1_d      = op1_data;
      op2_d      = op2_data;
      imm_d      = id_imm;
      alu_op_d   = id_alu_op;
      ctrl_d     = BUBBLE_CTRL;
      cnt_d      = '0;
      if (id_valid) begin
        ctrl_d.write_reg = id_write_reg;
        ctrl_d.write_r0  = id_write_r0;
        ctrl_d.mem_read  = id_mem_read;
        ctrl_d.muldiv    = id_muldiv;
        if (id_muldiv) begin
          cnt_d = CNT_W'(MULDIV_CYCLES - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      rn1_q      <= '0;
      rn2_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      imm_q      <= '0;
      alu_op_q   <= '0;
      ctrl_q     <= BUBBLE_CTRL;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      rn1_q      <= rn1_d;
      rn2_q      <= rn2_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      imm_q      <= imm_d;
      alu_op_q   <= alu_op_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled edges; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_id_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

  assign ex_valid    = ex_valid_q;
  assign RN1_EX      = rn1_q;
  assign RN2_EX      = rn2_q;
  assign op1_EX      = op1_q;
  assign op2_EX      = op2_q;
  assign Imm_EX      = imm_q;
  assign AluOp_EX    = alu_op_q;
  assign WriteReg_EX = ctrl_q.write_reg;
  assign WriteR0_EX  = ctrl_q.write_r0;
  assign MemRead_EX  = ctrl_q.mem_read;
  assign MulDiv_EX   = ctrl_q.muldiv;
  assign ex_busy     = busy_c;
  assign stall_id    = stall_id_c;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage (DATA_W=16, MULDIV_CYCLES=4).
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  RN1, RN2;
  logic [15:0] op1_data, op2_data, id_imm;
  logic [3:0]  id_alu_op;
  logic        id_write_reg, id_write_r0, id_mem_read, id_muldiv, flush;
  logic        ex_valid;
  logic [3:0]  RN1_EX, RN2_EX;
  logic [15:0] op1_EX, op2_EX, Imm_EX;
  logic [3:0]  AluOp_EX;
  logic        WriteReg_EX, WriteR0_EX, MemRead_EX, MulDiv_EX;
  logic        ex_busy, stall_id;
  logic [15:0] stall_count;

  id_ex_stage #(.DATA_W(16), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .RN1(RN1), .RN2(RN2),
    .op1_data(op1_data), .op2_data(op2_data), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_write_reg(id_write_reg), .id_write_r0(id_write_r0), .id_mem_read(id_mem_read),
    .id_muldiv(id_muldiv), .flush(flush), .ex_valid(ex_valid), .RN1_EX(RN1_EX),
    .RN2_EX(RN2_EX), .op1_EX(op1_EX), .op2_EX(op2_EX), .Imm_EX(Imm_EX),
    .AluOp_EX(AluOp_EX), .WriteReg_EX(WriteReg_EX), .WriteR0_EX(WriteR0_EX),
    .MemRead_EX(MemRead_EX), .MulDiv_EX(MulDiv_EX), .ex_busy(ex_busy),
    .stall_id(stall_id), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  rn1, rn2;
    logic [15:0] op1;
    logic        wr, mr, md, fl;
    logic        e_stall;
    logic        e_ev;
    logic [3:0]  e_rn1, e_rn2;
    logic [15:0] e_op1;
    logic        e_wr, e_mr, e_md, e_busy;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stalls = 0;

  function automatic vec_t mk(input logic v, input logic [3:0] rn1, input logic [3:0] rn2,
                              input logic [15:0] op1, input logic wr, input logic mr,
                              input logic md, input logic fl, input logic e_stall,
                              input logic e_ev, input logic [3:0] e_rn1, input logic [3:0] e_rn2,
                              input logic [15:0] e_op1, input logic e_wr, input logic e_mr,
                              input logic e_md, input logic e_busy);
    vec_t t;
    t.v = v; t.rn1 = rn1; t.rn2 = rn2; t.op1 = op1;
    t.wr = wr; t.mr = mr; t.md = md; t.fl = fl;
    t.e_stall = e_stall; t.e_ev = e_ev; t.e_rn1 = e_rn1; t.e_rn2 = e_rn2;
    t.e_op1 = e_op1; t.e_wr = e_wr; t.e_mr = e_mr; t.e_md = e_md; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [61:0] ex_bundle();
    return {ex_valid, RN1_EX, RN2_EX, op1_EX, op2_EX, Imm_EX,
            WriteReg_EX, WriteR0_EX, MemRead_EX, MulDiv_EX, ex_busy};
  endfunction

  task automatic drive(input vec_t t);
    id_valid     = t.v;
    RN1          = t.rn1;
    RN2          = t.rn2;
    op1_data     = t.op1;
    op2_data     = t.op1 + 16'd1;
    id_imm       = t.op1 + 16'd2;
    id_alu_op    = t.rn2;
    id_write_reg = t.wr;
    id_write_r0  = t.wr;
    id_mem_read  = t.mr;
    id_muldiv    = t.md;
    flush        = t.fl;
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] e_op2, e_imm;
    logic [61:0] exp_b;

    // Reset with random inputs: every output must read 0.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      id_valid = 1'($urandom); RN1 = 4'($urandom); RN2 = 4'($urandom);
      op1_data = 16'($urandom); op2_data = 16'($urandom); id_imm = 16'($urandom);
      id_alu_op = 4'($urandom); id_write_reg = 1'($urandom); id_write_r0 = 1'($urandom);
      id_mem_read = 1'($urandom); id_muldiv = 1'($urandom); flush = 1'($urandom);
    end
    #1;
    chk("reset_ex", 64'(ex_bundle()), 64'd0);
    chk("reset_misc", 64'({AluOp_EX, stall_id, stall_count}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //           v  rn1  rn2  op1       wr mr md fl  stl  ev ern1 ern2 eop1      ewr emr emd ebusy
    vecs.push_back(mk(1, 4'd3, 4'd0, 16'h1234, 1, 0, 0, 0, 0, 1, 4'd3, 4'd0, 16'h1234, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'd5, 4'd1, 16'h0005, 1, 1, 0, 0, 0, 1, 4'd5, 4'd1, 16'h0005, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'd2, 4'd5, 16'h00AA, 1, 0, 0, 0, 1, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd2, 4'd5, 16'h00AA, 1, 0, 0, 0, 0, 1, 4'd2, 4'd5, 16'h00AA, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'd6, 4'd7, 16'h0010, 1, 0, 1, 0, 0, 1, 4'd6, 4'd7, 16'h0010, 1, 0, 1, 1));
    vecs.push_back(mk(1, 4'd8, 4'd9, 16'h0020, 1, 0, 0, 0, 1, 1, 4'd6, 4'd7, 16'h0010, 1, 0, 1, 1));
    vecs.push_back(mk(1, 4'd8, 4'd9, 16'h0020, 1, 0, 0, 0, 1, 1, 4'd6, 4'd7, 16'h0010, 1, 0, 1, 1));
    vecs.push_back(mk(1, 4'd8, 4'd9, 16'h0020, 1, 0, 0, 0, 1, 1, 4'd6, 4'd7, 16'h0010, 1, 0, 1, 0));
    vecs.push_back(mk(1, 4'd8, 4'd9, 16'h0020, 1, 0, 0, 0, 0, 1, 4'd8, 4'd9, 16'h0020, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'd1, 4'd2, 16'h0030, 1, 0, 1, 0, 0, 1, 4'd1, 4'd2, 16'h0030, 1, 0, 1, 1));
    vecs.push_back(mk(1, 4'd3, 4'd4, 16'h0040, 1, 0, 0, 0, 1, 1, 4'd1, 4'd2, 16'h0030, 1, 0, 1, 1));
    vecs.push_back(mk(1, 4'd3, 4'd4, 16'h0040, 1, 0, 0, 1, 0, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd3, 4'd4, 16'h0040, 1, 0, 0, 0, 0, 1, 4'd3, 4'd4, 16'h0040, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'd9, 4'd0, 16'h0050, 1, 1, 0, 0, 0, 1, 4'd9, 4'd0, 16'h0050, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'd9, 4'd1, 16'h0060, 1, 0, 0, 1, 0, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hA, 4'hB, 16'h0070, 1, 1, 1, 0, 0, 0, 4'hA, 4'hB, 16'h0070, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd0, 4'd3, 16'h0080, 1, 1, 0, 0, 0, 1, 4'd0, 4'd3, 16'h0080, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'd0, 4'd0, 16'h0090, 1, 0, 0, 0, 1, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd0, 4'd0, 16'h0090, 1, 0, 0, 0, 0, 1, 4'd0, 4'd0, 16'h0090, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'd4, 4'd0, 16'h00A0, 1, 1, 0, 0, 0, 1, 4'd4, 4'd0, 16'h00A0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'd4, 4'd4, 16'h00B0, 1, 0, 0, 0, 0, 0, 4'd4, 4'd4, 16'h00B0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("stall_id[%0d]", i), 64'(stall_id), 64'(vecs[i].e_stall));
      if (vecs[i].e_stall) exp_stalls++;
      @(posedge clk);
      #1;
      e_op2 = (vecs[i].e_op1 == 16'h0) ? 16'h0 : vecs[i].e_op1 + 16'd1;
      e_imm = (vecs[i].e_op1 == 16'h0) ? 16'h0 : vecs[i].e_op1 + 16'd2;
      exp_b = {vecs[i].e_ev, vecs[i].e_rn1, vecs[i].e_rn2, vecs[i].e_op1, e_op2, e_imm,
               vecs[i].e_wr, vecs[i].e_wr, vecs[i].e_mr, vecs[i].e_md, vecs[i].e_busy};
      chk($sformatf("ex_regs[%0d]", i), 64'(ex_bundle()), 64'(exp_b));
    end

`ifdef ID_EX_STALL_CNT_EN
    chk("stall_count", 64'(stall_count), 64'(exp_stalls));
`else
    chk("stall_count", 64'(stall_count), 64'd0);
`endif

    // Async reset asserted mid mul/div clears everything immediately.
    @(negedge clk);
    drive(mk(1, 4'd7, 4'd7, 16'h00C0, 1, 0, 1, 0, 0, 0, 4'd0, 4'd0, 16'h0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("md_issue_busy", 64'({MulDiv_EX, ex_busy}), 64'b11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ex", 64'(ex_bundle()), 64'd0);
    chk("midreset_misc", 64'({AluOp_EX, stall_id, stall_count}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the CPU datapath. It sits between decode and execute. It latches the decoded operands, register numbers and control bits that the execute stage and the register-forwarding unit consume (`RN1_EX`, `WriteReg_EX`, `WriteR0_EX`, …). It also detects load-use hazards, holds execute for multi-cycle multiply/divide, and inserts bubbles on stall or flush.

## Interface
Parameters:
- `DATA_W`, 16, operand/immediate width
- `MULDIV_CYCLES`, 4, cycles a mul/div occupies EX (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  decode slot holds a real instruction
- `RN1`, `RN2`  in  4 each  decode-stage source register numbers
- `op1_data`, `op2_data`  in  DATA_W each  register-file read data
- `id_imm`  in  DATA_W  immediate
- `id_alu_op`  in  4  ALU function
- `id_write_reg`, `id_write_r0`, `id_mem_read`, `id_muldiv`  in  1 each  decode control bits
- `flush`  in  1  taken branch; kill the decode instruction
- `ex_valid`  out  1  EX holds a real instruction
- `RN1_EX`, `RN2_EX`  out  4 each  latched register numbers
- `op1_EX`, `op2_EX`, `Imm_EX`  out  DATA_W each  latched data
- `AluOp_EX`  out  4  latched ALU function
- `WriteReg_EX`, `WriteR0_EX`, `MemRead_EX`, `MulDiv_EX`  out  1 each  latched control
- `ex_busy`  out  1  mul/div still occupying EX
- `stall_id`  out  1  freeze PC and IF/ID (combinational)
- `stall_count`  out  16  stall statistic (see Configuration)

## Operation
- Hazard term `ld_use` = `ex_valid & MemRead_EX & WriteReg_EX & id_valid & (RN1_EX==RN1 | RN1_EX==RN2)`.
- Busy counter `cnt`, width clog2(MULDIV_CYCLES)+1. `ex_busy` = (`cnt`≠0).
- `stall_id` = `~flush & (ex_busy | ld_use)`.
- Per-edge priority, highest first:
  - flush: load a bubble and clear `cnt`.
  - ex_busy: hold all EX fields and decrement `cnt`.
  - ld_use: load a bubble.
  - otherwise: advance. Load all decode fields and set `ex_valid`=`id_valid`.
- Bubble: `ex_valid` and all control outputs = 0; RN, data and imm fields = 0.
- Advance with `id_valid`=0: fields load as-is, but control outputs are forced to 0.
- Advance with `id_valid & id_muldiv`: `cnt` loads MULDIV_CYCLES−1.
- Result: a mul/div stays in EX for MULDIV_CYCLES consecutive cycles, with `stall_id` high for the first MULDIV_CYCLES−1 of them. MULDIV_CYCLES=1 never stalls.
- Load-use costs exactly one bubble. The next cycle the load has left EX, so `ld_use` clears.
- Hazard comparisons are plain 4-bit equality; R0 is not special-cased.

## Timing
- Reset (async assert, any time, including mid-mul/div): all outputs 0, `cnt`=0, `stall_count`=0. Outputs stay 0 until the first edge after deassert.
- Latency: decode → EX outputs is 1 cycle. `stall_id`, `ex_busy` and `ld_use` are same-cycle combinational from state and inputs.
- `flush` coinciding with `ld_use` or `ex_busy`: flush wins. `stall_id`=0 that cycle and EX holds a bubble next cycle.
- `flush` with a mul/div in EX aborts it.
- `ld_use` while `ex_busy`: cannot occur, because MulDiv and MemRead are exclusive. If both are set, busy wins.

## Configuration
- `ID_EX_STALL_CNT_EN` defined: `stall_count` increments by 1 on each edge where `stall_id`=1, saturates at 0xFFFF, and is cleared only by reset.
- Not defined: `stall_count` is tied to 0 and no counter flops exist.

## Structure
- Shared package `cpu_pkg`: `REG_W`=4, `ALUOP_W`=4, and the bubble control-word constant.
- One sub-module, `id_ex_hazard`: combinational `ld_use`/`stall_id` logic. The register and counter stay in `id_ex_stage`.

## Test plan
- Reset check: hold `rst_n`=0 with random inputs → all outputs 0. Release, present `RN1`=3, `op1_data`=0x1234, `id_write_reg`=1, `id_valid`=1 → next cycle `RN1_EX`=3, `op1_EX`=0x1234, `WriteReg_EX`=1, `ex_valid`=1.
- Load-use: load to R5 in EX (`MemRead_EX`=1, `WriteReg_EX`=1, `RN1_EX`=5), decode `RN2`=5 → `stall_id`=1 for one cycle, one bubble (`ex_valid`=0), then the decode instruction enters EX.
- Mul/div timing: with MULDIV_CYCLES=4, issue `id_muldiv` → `ex_busy`/`stall_id` high for 3 cycles and EX fields constant for 4 cycles.
- Flush during mul/div: assert `flush` in the 2nd busy cycle → `stall_id`=0 immediately, bubble next cycle, `ex_busy`=0.
- Flush vs load-use: `flush` and a load-use match in the same cycle → `stall_id`=0, bubble loaded.
- Stall counter: with `ID_EX_STALL_CNT_EN`, after the above sequences → `stall_count` equals the number of `stall_id`-high edges. Force 0xFFFF and stall again → stays 0xFFFF. Without the macro → always 0.
